// File: rtl/pipe_cmd_bridge_if.sv
// rtl/pipe_cmd_bridge_if.sv - host pipe / sequencer signal bundle for pipe_cmd_bridge
// Ports (bridge side = master):
//   rx_byte/rx_valid -> rx_ready                    host command byte stream in
//   cmd_valid/cmd_type/cmd_tag/cmd_length/
//   cmd_address/cmd_data/cmd_known <- cmd_ack       held command record out
//   rsp_valid/rsp_type/rsp_status/rsp_tag/
//   rsp_read_data -> rsp_ready                      response fields in
//   tx_byte/tx_valid <- tx_ready                    host response byte stream out
//   rx_err_cnt                                      timed-out frame counter out
interface pipe_cmd_bridge_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_type;
  logic [7:0]  cmd_tag;
  logic [15:0] cmd_length;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;
  logic        cmd_known;
  logic        cmd_ack;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_type;
  logic [7:0]  rsp_status;
  logic [7:0]  rsp_tag;
  logic [31:0] rsp_read_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_err_cnt;

  modport master (
    input  rx_byte, rx_valid, cmd_ack,
    input  rsp_valid, rsp_type, rsp_status, rsp_tag, rsp_read_data, tx_ready,
    output rx_ready, cmd_valid, cmd_type, cmd_tag, cmd_length, cmd_address, cmd_data, cmd_known,
    output rsp_ready, tx_byte, tx_valid, rx_err_cnt
  );

  modport slave (
    output rx_byte, rx_valid, cmd_ack,
    output rsp_valid, rsp_type, rsp_status, rsp_tag, rsp_read_data, tx_ready,
    input  rx_ready, cmd_valid, cmd_type, cmd_tag, cmd_length, cmd_address, cmd_data, cmd_known,
    input  rsp_ready, tx_byte, tx_valid, rx_err_cnt
  );
endinterface

// File: rtl/pipe_cmd_bridge.sv
// rtl/pipe_cmd_bridge.sv - 12-byte command deserialiser / response serialiser bridge
// Ports:
//   sys_clk    single clock
//   sys_rst_n  asynchronous active-low reset
//   bus        pipe_cmd_bridge_if.master (rx stream, command record, response fields, tx stream)
// Params: RX_TIMEOUT idle cycles before a partial command frame is dropped,
//         TS_WIDTH free-running timestamp width (low 32 bits go out in responses)
module pipe_cmd_bridge #(
  parameter int RX_TIMEOUT = 1000,
  parameter int TS_WIDTH   = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  pipe_cmd_bridge_if.master   bus
);

  localparam int IDLE_W = $clog2(RX_TIMEOUT + 1);

  typedef enum logic {RX_ASSEMBLE, RX_HOLD} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t           rx_state;
  logic [3:0]          rx_idx;
  logic [87:0]         rx_buf;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                cmd_valid_q;
  logic [7:0]          cmd_type_q;
  logic [7:0]          cmd_tag_q;
  logic [15:0]         cmd_length_q;
  logic [31:0]         cmd_address_q;
  logic [31:0]         cmd_data_q;
  logic [7:0]          err_cnt_q;

  tx_state_t           tx_state;
  logic [3:0]          tx_idx;
  logic [87:0]         tx_shift;
  logic [7:0]          tx_byte_q;
  logic                tx_valid_q;
  logic                rsp_ready_q;
  logic [TS_WIDTH-1:0] ts_cnt;

  logic rx_accept;
  logic cmd_known_c;

  assign rx_accept = bus.rx_valid & ~cmd_valid_q;

  // Bytes shift in at the top so that after bytes 0..10 byte k sits at rx_buf[8k+:8];
  // byte 11 is taken straight from rx_byte when the record loads.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state      <= RX_ASSEMBLE;
      rx_idx        <= 4'd0;
      rx_buf        <= '0;
      idle_cnt      <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= 8'h00;
      cmd_tag_q     <= 8'h00;
      cmd_length_q  <= 16'h0000;
      cmd_address_q <= 32'h0;
      cmd_data_q    <= 32'h0;
      err_cnt_q     <= 8'h00;
    end else begin
      case (rx_state)
        RX_ASSEMBLE: begin
          if (rx_accept) begin
            idle_cnt <= '0;
            if (rx_idx == 4'd11) begin
              cmd_type_q    <= rx_buf[7:0];
              cmd_tag_q     <= rx_buf[15:8];
              cmd_length_q  <= rx_buf[31:16];
              cmd_address_q <= rx_buf[63:32];
              cmd_data_q    <= {bus.rx_byte, rx_buf[87:64]};
              cmd_valid_q   <= 1'b1;
              rx_idx        <= 4'd0;
              rx_state      <= RX_HOLD;
            end else begin
              rx_buf <= {bus.rx_byte, rx_buf[87:8]};
              rx_idx <= rx_idx + 4'd1;
            end
          end else if (rx_idx != 4'd0) begin
            // Stale partial frame: drop it; the shift buffer is refilled by the next frame.
            if (idle_cnt == IDLE_W'(RX_TIMEOUT - 1)) begin
              idle_cnt <= '0;
              rx_idx   <= 4'd0;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        RX_HOLD: begin
          if (bus.cmd_ack) begin
            cmd_valid_q <= 1'b0;
            rx_state    <= RX_ASSEMBLE;
          end
        end
        default: rx_state <= RX_ASSEMBLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ts_cnt <= '0;
    else            ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  // tx_byte holds the byte on offer; tx_shift holds the remaining bytes, next one lowest.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state    <= TX_IDLE;
      tx_idx      <= 4'd0;
      tx_shift    <= '0;
      tx_byte_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      rsp_ready_q <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.rsp_valid && rsp_ready_q) begin
            tx_shift    <= {ts_cnt[31:0], bus.rsp_read_data, 8'h00, bus.rsp_status, bus.rsp_tag};
            tx_byte_q   <= bus.rsp_type;
            tx_valid_q  <= 1'b1;
            tx_idx      <= 4'd0;
            rsp_ready_q <= 1'b0;
            tx_state    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (bus.tx_ready) begin
            if (tx_idx == 4'd11) begin
              tx_valid_q  <= 1'b0;
              rsp_ready_q <= 1'b1;
              tx_state    <= TX_IDLE;
            end else begin
              tx_byte_q <= tx_shift[7:0];
              tx_shift  <= {8'h00, tx_shift[87:8]};
              tx_idx    <= tx_idx + 4'd1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_known_c = 1'b0;
    case (cmd_type_q)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'hFF: cmd_known_c = 1'b1;
      default: cmd_known_c = 1'b0;
    endcase
  end

  assign bus.rx_ready    = ~cmd_valid_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_type    = cmd_type_q;
  assign bus.cmd_tag     = cmd_tag_q;
  assign bus.cmd_length  = cmd_length_q;
  assign bus.cmd_address = cmd_address_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.cmd_known   = cmd_known_c;
  assign bus.rsp_ready   = rsp_ready_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.rx_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pipe_cmd_bridge.sv
// tb/tb_pipe_cmd_bridge.sv - directed self-checking bench for pipe_cmd_bridge
module tb_pipe_cmd_bridge;
  localparam int RX_TIMEOUT = 1000;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] tb_ts;
  int          errors = 0;
  int          checks = 0;

  pipe_cmd_bridge_if bus();

  pipe_cmd_bridge #(.RX_TIMEOUT(RX_TIMEOUT), .TS_WIDTH(32)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference cycle counter: zero out of reset, +1 per clock.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) tb_ts <= 32'h0;
    else            tb_ts <= tb_ts + 32'h1;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [95:0] mk_cmd(input logic [7:0] t, input logic [7:0] g,
                                         input logic [15:0] l, input logic [31:0] a,
                                         input logic [31:0] d);
    return {d, a, l, g, t};
  endfunction

  task automatic send_bytes(input logic [95:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.rx_byte  = f[i*8 +: 8];
      bus.rx_valid = 1'b1;
      tick();
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic ack();
    bus.cmd_ack = 1'b1;
    tick();
    bus.cmd_ack = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.rx_ready, bus.rsp_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b expected 11", {bus.rx_ready, bus.rsp_ready});
    end
    checks++;
    if ({bus.cmd_valid, bus.tx_valid, bus.cmd_known} !== 3'b000) begin
      errors++; $display("FAIL reset_valids: got %b expected 000", {bus.cmd_valid, bus.tx_valid, bus.cmd_known});
    end
    checks++;
    if ({bus.rx_err_cnt, bus.tx_byte, bus.cmd_type, bus.cmd_data} !== 56'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus.rx_err_cnt, bus.tx_byte, bus.cmd_type, bus.cmd_data});
    end
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cmd_basic();
    logic [95:0] f;
    f = mk_cmd(8'h01, 8'h05, 16'h0001, 32'h0000_0010, 32'h0);
    send_bytes(f, 0, 10);
    checks++;
    if ({bus.cmd_valid, bus.rx_ready} !== 2'b01) begin
      errors++; $display("FAIL basic_pre_last: got %b expected 01", {bus.cmd_valid, bus.rx_ready});
    end
    send_bytes(f, 11, 11);
    checks++;
    if ({bus.cmd_valid, bus.rx_ready, bus.cmd_known} !== 3'b101) begin
      errors++; $display("FAIL basic_flags: got %b expected 101", {bus.cmd_valid, bus.rx_ready, bus.cmd_known});
    end
    checks++;
    if ({bus.cmd_type, bus.cmd_tag, bus.cmd_length, bus.cmd_address, bus.cmd_data} !== 96'h01_05_0001_00000010_00000000) begin
      errors++; $display("FAIL basic_fields: got %h expected 010500010000001000000000",
                         {bus.cmd_type, bus.cmd_tag, bus.cmd_length, bus.cmd_address, bus.cmd_data});
    end
  endtask

  task automatic test_hold();
    logic [95:0] f;
    f = mk_cmd(8'h04, 8'h06, 16'h0002, 32'h0000_1000, 32'hCAFE_F00D);
    bus.rx_byte  = f[7:0];
    bus.rx_valid = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.rx_ready, bus.cmd_valid, bus.cmd_tag} !== 10'b01_0000_0101) begin
      errors++; $display("FAIL hold_stall: got %b expected 0100000101", {bus.rx_ready, bus.cmd_valid, bus.cmd_tag});
    end
    ack();
    checks++;
    if ({bus.cmd_valid, bus.rx_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_ack: got %b expected 01", {bus.cmd_valid, bus.rx_ready});
    end
    // The offered byte must be consumed exactly once, as byte 0 of the next frame.
    send_bytes(f, 0, 11);
    checks++;
    if ({bus.cmd_valid, bus.cmd_type, bus.cmd_tag, bus.cmd_length, bus.cmd_address, bus.cmd_data}
        !== {1'b1, 96'h04_06_0002_00001000_CAFEF00D}) begin
      errors++; $display("FAIL hold_next_frame: got %h", {bus.cmd_type, bus.cmd_tag, bus.cmd_length, bus.cmd_address, bus.cmd_data});
    end
    ack();
    ack();
    checks++;
    if ({bus.cmd_valid, bus.rx_ready} !== 2'b01) begin
      errors++; $display("FAIL idle_ack: got %b expected 01", {bus.cmd_valid, bus.rx_ready});
    end
  endtask

  task automatic test_timeout();
    logic [95:0] f;
    f = mk_cmd(8'h02, 8'h07, 16'h0003, 32'h0000_0020, 32'h1111_2222);
    send_bytes(f, 0, 2);
    repeat (RX_TIMEOUT - 1) tick();
    checks++;
    if (bus.rx_err_cnt !== 8'd0) begin
      errors++; $display("FAIL timeout_early: got %0d expected 0", bus.rx_err_cnt);
    end
    tick();
    checks++;
    if ({bus.rx_err_cnt, bus.cmd_valid} !== {8'd1, 1'b0}) begin
      errors++; $display("FAIL timeout_hit: got err=%0d valid=%b expected err=1 valid=0", bus.rx_err_cnt, bus.cmd_valid);
    end
    f = mk_cmd(8'h04, 8'h08, 16'h0001, 32'h0000_2000, 32'hDEAD_BEEF);
    send_bytes(f, 0, 11);
    checks++;
    if ({bus.cmd_valid, bus.cmd_type, bus.cmd_tag, bus.cmd_data, bus.rx_err_cnt} !== {1'b1, 8'h04, 8'h08, 32'hDEADBEEF, 8'd1}) begin
      errors++; $display("FAIL timeout_recover: got type=%h tag=%h data=%h err=%0d", bus.cmd_type, bus.cmd_tag, bus.cmd_data, bus.rx_err_cnt);
    end
    ack();
  endtask

  task automatic test_known();
    logic [7:0] types [6];
    logic       known [6];
    types = '{8'h10, 8'h11, 8'hFF, 8'h7A, 8'h00, 8'h02};
    known = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      send_bytes(mk_cmd(types[i], 8'(i), 16'h0, 32'h0, 32'h0), 0, 11);
      checks++;
      if ({bus.cmd_valid, bus.cmd_type, bus.cmd_known} !== {1'b1, types[i], known[i]}) begin
        errors++; $display("FAIL known_%h: got valid=%b type=%h known=%b expected known=%b",
                           types[i], bus.cmd_valid, bus.cmd_type, bus.cmd_known, known[i]);
      end
      ack();
    end
  endtask

  task automatic test_rsp();
    logic [95:0] v;
    logic [31:0] t;
    bus.rsp_type = 8'h03; bus.rsp_tag = 8'h05; bus.rsp_status = 8'h00; bus.rsp_read_data = 32'h1234_5678;
    bus.tx_ready = 1'b1;
    bus.rsp_valid = 1'b1;
    t = tb_ts;
    tick();
    bus.rsp_valid = 1'b0;
    v = {t, 32'h1234_5678, 8'h00, 8'h00, 8'h05, 8'h03};
    checks++;
    if (bus.rsp_ready !== 1'b0) begin
      errors++; $display("FAIL rsp_ready_drop: got %b expected 0", bus.rsp_ready);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({bus.tx_valid, bus.tx_byte} !== {1'b1, v[i*8 +: 8]}) begin
        errors++; $display("FAIL rsp_byte%0d: got valid=%b byte=%h expected byte=%h", i, bus.tx_valid, bus.tx_byte, v[i*8 +: 8]);
      end
      tick();
    end
    checks++;
    if ({bus.tx_valid, bus.rsp_ready} !== 2'b01) begin
      errors++; $display("FAIL rsp_done: got %b expected 01", {bus.tx_valid, bus.rsp_ready});
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [95:0] v;
    logic [31:0] t;
    logic [7:0]  hold;
    logic        stalled;
    int          n;
    bus.rsp_type = 8'hEE; bus.rsp_tag = 8'h09; bus.rsp_status = 8'h01; bus.rsp_read_data = 32'h0;
    bus.tx_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    t = tb_ts;
    tick();
    bus.rsp_valid = 1'b0;
    v = {t, 32'h0, 8'h00, 8'h01, 8'h09, 8'hEE};
    n = 0;
    for (int c = 0; c < 100 && n < 12; c++) begin
      bus.tx_ready = (c % 3 == 2);
      if (bus.tx_valid && bus.tx_ready) begin
        checks++;
        if (bus.tx_byte !== v[n*8 +: 8]) begin
          errors++; $display("FAIL stall_byte%0d: got %h expected %h", n, bus.tx_byte, v[n*8 +: 8]);
        end
        n++;
      end
      hold    = bus.tx_byte;
      stalled = bus.tx_valid && !bus.tx_ready;
      tick();
      if (stalled) begin
        checks++;
        if ({bus.tx_valid, bus.tx_byte} !== {1'b1, hold}) begin
          errors++; $display("FAIL stall_stable: got valid=%b byte=%h expected byte=%h", bus.tx_valid, bus.tx_byte, hold);
        end
      end
    end
    bus.tx_ready = 1'b0;
    checks++;
    if ({n, bus.tx_valid, bus.rsp_ready} !== {32'd12, 2'b01}) begin
      errors++; $display("FAIL stall_done: got bytes=%0d valid=%b ready=%b expected 12/0/1", n, bus.tx_valid, bus.rsp_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] f;
    logic [31:0] ta, tb2;
    logic [7:0]  got [$];
    logic [191:0] v;
    int          caps;
    f = mk_cmd(8'h03, 8'h0C, 16'h0010, 32'hA000_0040, 32'h5555_AAAA);
    caps = 0; ta = 0; tb2 = 0;
    fork
      send_bytes(f, 0, 11);
      begin
        bus.rsp_type = 8'h01; bus.rsp_tag = 8'h21; bus.rsp_status = 8'h00; bus.rsp_read_data = 32'h0BAD_F00D;
        bus.rsp_valid = 1'b1;
        bus.tx_ready  = 1'b1;
        for (int c = 0; c < 60 && got.size() < 24; c++) begin
          if (bus.rsp_valid && bus.rsp_ready) begin
            if (caps == 0) ta = tb_ts; else tb2 = tb_ts;
            caps++;
          end
          if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_byte);
          tick();
          if (caps == 1) begin
            bus.rsp_type = 8'h02; bus.rsp_tag = 8'h22; bus.rsp_status = 8'h01; bus.rsp_read_data = 32'h0;
          end
          if (caps == 2) bus.rsp_valid = 1'b0;
        end
        bus.rsp_valid = 1'b0;
        bus.tx_ready  = 1'b0;
      end
    join
    checks++;
    if ({bus.cmd_valid, bus.cmd_type, bus.cmd_tag, bus.cmd_length, bus.cmd_address, bus.cmd_data}
        !== {1'b1, 96'h03_0C_0010_A0000040_5555AAAA}) begin
      errors++; $display("FAIL b2b_cmd: got %h", {bus.cmd_type, bus.cmd_tag, bus.cmd_length, bus.cmd_address, bus.cmd_data});
    end
    ack();
    checks++;
    if (got.size() !== 24) begin
      errors++; $display("FAIL b2b_count: got %0d expected 24", got.size());
    end else begin
      v = {tb2, 32'h0, 8'h00, 8'h01, 8'h22, 8'h02, ta, 32'h0BAD_F00D, 8'h00, 8'h00, 8'h21, 8'h01};
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (got[i] !== v[i*8 +: 8]) begin
          errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got[i], v[i*8 +: 8]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [95:0] f;
    f = mk_cmd(8'h11, 8'h33, 16'h0000, 32'h0, 32'h0);
    send_bytes(mk_cmd(8'h01, 8'h44, 16'h1, 32'h1, 32'h1), 0, 4);
    bus.rsp_type = 8'h04; bus.rsp_tag = 8'h01; bus.rsp_status = 8'h00; bus.rsp_read_data = 32'h0;
    bus.rsp_valid = 1'b1; bus.tx_ready = 1'b1;
    tick();
    bus.rsp_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.tx_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got tx_valid=%b expected 1", bus.tx_valid);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_valid, bus.rsp_ready, bus.rx_ready, bus.cmd_valid, bus.rx_err_cnt} !== {4'b0110, 8'd0}) begin
      errors++; $display("FAIL rstmid_async: got %b expected 011000000000",
                         {bus.tx_valid, bus.rsp_ready, bus.rx_ready, bus.cmd_valid, bus.rx_err_cnt});
    end
    bus.tx_ready = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    send_bytes(f, 0, 11);
    checks++;
    if ({bus.cmd_valid, bus.cmd_type, bus.cmd_tag, bus.cmd_known} !== {1'b1, 8'h11, 8'h33, 1'b1}) begin
      errors++; $display("FAIL rstmid_realign: got type=%h tag=%h expected 11/33", bus.cmd_type, bus.cmd_tag);
    end
    ack();
  endtask

  initial begin
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; bus.cmd_ack = 1'b0;
    bus.rsp_valid = 1'b0; bus.rsp_type = 8'h00; bus.rsp_status = 8'h00; bus.rsp_tag = 8'h00;
    bus.rsp_read_data = 32'h0; bus.tx_ready = 1'b0;
    test_reset();
    test_cmd_basic();
    test_hold();
    test_timeout();
    test_known();
    test_rsp();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
